// File: rtl/scratchpad_mem_apb.sv
// rtl/scratchpad_mem_apb.sv - APB-attached banked scratchpad with one wait state per transfer
// Words are BUS_WIDTH wide, byte-strobed on write, cleared by reset.
module scratchpad_mem_apb #(
  parameter int DATA_WIDTH = 32,
  parameter int BUS_WIDTH  = 64,
  parameter int ADDR_WIDTH = 16,
  parameter int SPN        = 4,
  parameter int DEPTH      = 16,
  parameter int BYTE       = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      psel_i,
  input  logic                      penable_i,
  input  logic                      pwrite_i,
  input  logic [ADDR_WIDTH-1:0]     paddr_i,
  input  logic [BUS_WIDTH-1:0]      pwdata_i,
  input  logic [BUS_WIDTH/BYTE-1:0] pstrb_i,
  output logic [BUS_WIDTH-1:0]      prdata_o,
  output logic                      pready_o,
  output logic                      pslverr_o
);

  localparam int STRB_W = BUS_WIDTH / BYTE;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int WIDX_W = ADDR_WIDTH - OFF_W;
  localparam int BANK_W = (SPN > 1) ? $clog2(SPN) : 1;
  localparam int ROW_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [WIDX_W-1:0] WORDS = WIDX_W'(SPN * DEPTH);

  // Matrix elements must pack evenly into a bus word.
  if (BUS_WIDTH % DATA_WIDTH != 0) begin : g_bad_width
    $error("BUS_WIDTH must be a multiple of DATA_WIDTH");
  end

  typedef enum logic {IDLE, RESP} state_t;

  state_t              state_q, state_d;
  logic [BUS_WIDTH-1:0] mem [SPN][DEPTH];

  logic                write_q;
  logic                valid_q;
  logic [BANK_W-1:0]   bank_q;
  logic [ROW_W-1:0]    row_q;

  logic [WIDX_W-1:0]   word_idx;
  logic [BANK_W-1:0]   bank;
  logic [ROW_W-1:0]    row;
  logic                addr_ok;
  logic                access;
  logic                start;
  logic                commit;

  assign word_idx = paddr_i[ADDR_WIDTH-1:OFF_W];
  assign row      = word_idx[ROW_W-1:0];
  assign bank     = BANK_W'(word_idx >> ROW_W);
  assign addr_ok  = (paddr_i[OFF_W-1:0] == '0) && (word_idx < WORDS);
  assign access   = psel_i && penable_i;
  assign start    = (state_q == IDLE) && access;
  assign commit   = (state_q == RESP) && access && write_q && valid_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (access) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      write_q   <= 1'b0;
      valid_q   <= 1'b0;
      bank_q    <= '0;
      row_q     <= '0;
      pready_o  <= 1'b0;
      pslverr_o <= 1'b0;
      prdata_o  <= '0;
      for (int b = 0; b < SPN; b++) begin
        for (int r = 0; r < DEPTH; r++) begin
          mem[b][r] <= '0;
        end
      end
    end else begin
      state_q   <= state_d;
      pready_o  <= start;
      pslverr_o <= start && !addr_ok;
      if (start) begin
        write_q <= pwrite_i;
        valid_q <= addr_ok;
        bank_q  <= bank;
        row_q   <= row;
        if (!pwrite_i) prdata_o <= addr_ok ? mem[bank][row] : '0;
      end
      // Write data and strobes are taken from the access phase that ends the transfer.
      if (commit) begin
        for (int k = 0; k < STRB_W; k++) begin
          if (pstrb_i[k]) mem[bank_q][row_q][k*BYTE +: BYTE] <= pwdata_i[k*BYTE +: BYTE];
        end
      end
    end
  end

endmodule

// File: tb/tb_scratchpad_mem_apb.sv
// tb/tb_scratchpad_mem_apb.sv - directed and randomized APB checks of scratchpad_mem_apb
module tb_scratchpad_mem_apb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        psel, penable, pwrite;
  logic [15:0] paddr;
  logic [63:0] pwdata;
  logic [7:0]  pstrb;
  logic [63:0] prdata;
  logic        pready, pslverr;

  int total = 0;
  int passed = 0;
  int failed = 0;

  logic [63:0] model_mem [64];
  logic [63:0] last_rdata;

  scratchpad_mem_apb dut (
    .clk_i(clk), .rst_ni(rst_n), .psel_i(psel), .penable_i(penable),
    .pwrite_i(pwrite), .paddr_i(paddr), .pwdata_i(pwdata), .pstrb_i(pstrb),
    .prdata_o(prdata), .pready_o(pready), .pslverr_o(pslverr)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit addr_valid(input logic [15:0] a);
    return (a % 8 == 0) && (a / 8 < 64);
  endfunction

  task automatic model_clear();
    foreach (model_mem[i]) model_mem[i] = 64'h0;
    last_rdata = 64'h0;
  endtask

  // One APB transfer: setup, access, response; optional abort drops psel in RESP.
  task automatic xfer(input bit wr, input logic [15:0] addr, input logic [63:0] data,
                      input logic [7:0] strb, input bit abort, input string tag);
    bit ok;
    logic [63:0] exp_rd;
    ok = addr_valid(addr);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data; pstrb = strb;
    @(negedge clk);
    penable = 1'b1;
    check({tag, " pready_setup"}, pready, 0);
    @(posedge clk); #1;
    check({tag, " pready_resp"}, pready, 1);
    check({tag, " pslverr"}, pslverr, !ok);
    if (!wr) begin
      exp_rd = ok ? model_mem[addr / 8] : 64'h0;
      last_rdata = exp_rd;
    end
    check({tag, " prdata"}, prdata, last_rdata);
    if (abort) psel = 1'b0;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    check({tag, " pready_idle"}, pready, 0);
    check({tag, " pslverr_idle"}, pslverr, 0);
    if (wr && ok && !abort)
      for (int k = 0; k < 8; k++)
        if (strb[k]) model_mem[addr / 8][k*8 +: 8] = data[k*8 +: 8];
  endtask

  initial begin
    logic [15:0] a;
    int r;
    rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0;
    model_clear();
    repeat (3) @(negedge clk);
    check("reset pready", pready, 0);
    check("reset pslverr", pslverr, 0);
    check("reset prdata", prdata, 0);
    rst_n = 1'b1;

    xfer(0, 16'h000, 64'h0, 8'h00, 0, "rd000_after_reset");
    check("rd000 value", prdata, 64'h0);

    xfer(1, 16'h088, 64'h1122334455667788, 8'hFF, 0, "wr088_full");
    xfer(0, 16'h088, 64'h0, 8'hFF, 0, "rd088_full");
    check("rd088 full value", prdata, 64'h1122334455667788);
    xfer(1, 16'h088, 64'hAAAAAAAAAAAAAAAA, 8'h0F, 0, "wr088_low");
    xfer(0, 16'h088, 64'h0, 8'h00, 0, "rd088_low");
    check("rd088 merged value", prdata, 64'h11223344AAAAAAAA);

    xfer(1, 16'h088, 64'h5555555555555555, 8'h00, 0, "wr088_nostrb");
    xfer(0, 16'h088, 64'h0, 8'h00, 0, "rd088_nostrb");

    xfer(1, 16'h200, 64'hDEADBEEFDEADBEEF, 8'hFF, 0, "wr200_oor");
    xfer(1, 16'h084, 64'hDEADBEEFDEADBEEF, 8'hFF, 0, "wr084_misaligned");
    xfer(0, 16'h1F8, 64'h0, 8'h00, 0, "rd1F8");
    check("rd1F8 value", prdata, 64'h0);
    xfer(0, 16'h200, 64'h0, 8'h00, 0, "rd200_oor");
    xfer(0, 16'h080, 64'h0, 8'h00, 0, "rd080_untouched");

    // Stray penable without psel must not start a transfer.
    @(negedge clk); penable = 1'b1; pwrite = 1'b1; paddr = 16'h0F0; pstrb = 8'hFF;
    pwdata = 64'hFFFFFFFFFFFFFFFF;
    repeat (3) begin @(negedge clk); check("stray penable pready", pready, 0); end
    penable = 1'b0;
    xfer(0, 16'h0F0, 64'h0, 8'h00, 0, "rd0F0_after_stray");

    xfer(1, 16'h010, 64'h0123456789ABCDEF, 8'hFF, 1, "wr010_abort");
    xfer(0, 16'h010, 64'h0, 8'h00, 0, "rd010_after_abort");
    check("rd010 value", prdata, 64'h0);

    // Reset during the response of a write.
    xfer(1, 16'h1F8, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 0, "wr1F8");
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 16'h000;
    pwdata = 64'hCAFEF00DCAFEF00D; pstrb = 8'hFF;
    @(negedge clk); penable = 1'b1;
    @(posedge clk); #1;
    check("rst_mid pready_resp", pready, 1);
    rst_n = 1'b0;
    #1;
    check("rst_mid pready_drop", pready, 0);
    check("rst_mid pslverr", pslverr, 0);
    model_clear();
    @(posedge clk); @(negedge clk);
    psel = 1'b0; penable = 1'b0;
    rst_n = 1'b1;
    xfer(0, 16'h1F8, 64'h0, 8'h00, 0, "rd1F8_after_rst");
    check("rd1F8 after reset", prdata, 64'h0);
    xfer(0, 16'h000, 64'h0, 8'h00, 0, "rd000_after_rst");
    check("rd000 after reset", prdata, 64'h0);

    // Randomized traffic against the array model.
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      if (r < 7)       a = 16'($urandom_range(0, 63) * 8);
      else if (r == 7) a = 16'($urandom_range(0, 3) * 8 + 16'h080);
      else if (r == 8) a = 16'($urandom_range(0, 63) * 8 + $urandom_range(1, 7));
      else             a = 16'($urandom_range(64, 8191) * 8);
      xfer($urandom_range(0, 1) == 1, a, {$urandom(), $urandom()}, 8'($urandom()),
           $urandom_range(0, 7) == 0, $sformatf("rand%0d", i));
    end
    for (int w = 0; w < 64; w++) xfer(0, 16'(w * 8), 64'h0, 8'h00, 0, $sformatf("sweep%0d", w));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
